// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and output reduction for fir_filter_n
// FIR_SAT_EN selects clamping reduction instead of wrap-around.
package fir_pkg;

  localparam int DEF_TAPS = 3;

  function automatic int coef_addr_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  localparam int DEF_COEF_ADDR_W = coef_addr_width(DEF_TAPS);

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Result is sign-extended to 64 bits; callers keep the low out_w bits.
  function automatic logic signed [63:0] reduce_acc(input logic signed [63:0] acc,
                                                    input int out_w);
`ifdef FIR_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
`else
    return (acc <<< (64 - out_w)) >>> (64 - out_w);
`endif
  endfunction

`ifdef FIR_SAT_EN
  function automatic logic sat_hit(input logic signed [63:0] acc, input int out_w);
    return (acc > ((64'sd1 <<< (out_w - 1)) - 64'sd1)) || (acc < -(64'sd1 <<< (out_w - 1)));
  endfunction
`endif

endpackage

// File: rtl/fir_adder_tree.sv
// rtl/fir_adder_tree.sv - combinational signed sum of TAPS products at ACC_W
module fir_adder_tree #(
  parameter int TAPS  = 3,
  parameter int P_W   = 16,
  parameter int ACC_W = 18
) (
  input  logic [TAPS-1:0][P_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum
);

  // Each product is sign-extended before summing so the total never overflows.
  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = sum + ACC_W'(signed'(prod[k]));
    end
  end

endmodule

// File: rtl/fir_filter_n.sv
// rtl/fir_filter_n.sv - N-tap signed FIR, programmable coefficients, valid/ready stream
// FIR_SAT_EN: clamp results to OUT_W and report out_sat; otherwise wrap.
module fir_filter_n
  import fir_pkg::*;
#(
  parameter int TAPS   = 3,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush,
  input  logic                                coef_we,
  input  logic [coef_addr_width(TAPS)-1:0]    coef_addr,
  input  logic [COEF_W-1:0]                   coef_wdata,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_W-1:0]                   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_W-1:0]                    out_data,
  output logic                                out_sat
);

  localparam int P_W   = DATA_W + COEF_W;
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic [TAPS-1:0][P_W-1:0] p_q;
  logic                     v0_q;
  logic                     v1_q;
  logic                     adv;
  logic                     accept;
  logic signed [ACC_W-1:0]  acc;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  // Delay line; v0_q marks a freshly shifted sample not yet multiplied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      v0_q <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      v0_q <= 1'b0;
    end else begin
      if (accept) begin
        x_q[0] <= in_data;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      end
      if (adv) v0_q <= accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) c_q[k] <= '0;
    end else if (coef_we && (int'(coef_addr) < TAPS)) begin
      c_q[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q  <= '0;
      v1_q <= 1'b0;
    end else if (flush) begin
      v1_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < TAPS; k++) p_q[k] <= P_W'(x_q[k]) * P_W'(c_q[k]);
      v1_q <= v0_q;
    end
  end

  fir_adder_tree #(
    .TAPS  (TAPS),
    .P_W   (P_W),
    .ACC_W (ACC_W)
  ) u_adder_tree (
    .prod (p_q),
    .sum  (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_data  <= OUT_W'(reduce_acc(64'(acc), OUT_W));
      out_valid <= v1_q;
    end
  end

`ifdef FIR_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat <= 1'b0;
    end else if (flush) begin
      out_sat <= 1'b0;
    end else if (adv) begin
      out_sat <= sat_hit(64'(acc), OUT_W);
    end
  end
`else
  assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_fir_filter_n.sv
// tb/tb_fir_filter_n.sv - scoreboard bench for fir_filter_n (TAPS=3, 8/8/16 bits)
module tb_fir_filter_n;

  typedef struct packed {
    logic [15:0] d;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [7:0]  coef_wdata = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_sat;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          acc_cyc = 0;
  int          lat0 = 0;
  logic        prev_ov = 1'b0;
  logic [15:0] held = '0;

  fir_filter_n #(.TAPS(3), .DATA_W(8), .COEF_W(8), .OUT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int acc);
    exp_t e;
    e.d = 16'(acc);
    e.s = 1'b0;
`ifdef FIR_SAT_EN
    if (acc > 32767) begin
      e.d = 16'h7fff;
      e.s = 1'b1;
    end else if (acc < -32768) begin
      e.d = 16'h8000;
      e.s = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) rise_cyc = cyc;
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_sat", 32'(out_sat), 32'(e.s));
        end
      end
    end
  endtask

  task automatic send(input int d, input bit push, input int acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = 8'(d);
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    if (push) exp_q.push_back(model(acc));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_we    = 1'b1;
    coef_addr  = 2'(a);
    coef_wdata = 8'(d);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sat", 32'(out_sat), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Impulse through c = {5,-3,7}
    wr_coef(0, 5);
    wr_coef(1, -3);
    wr_coef(2, 7);
    send(1, 1'b1, 5);
    lat0 = acc_cyc;
    send(0, 1'b1, -3);
    send(0, 1'b1, 7);
    send(0, 1'b1, 0);
    drain();
    chk("latency", 32'(rise_cyc - lat0), 32'd2);

    // Worst-case magnitude: all -128
    wr_coef(0, -128);
    wr_coef(1, -128);
    wr_coef(2, -128);
    send(-128, 1'b1, 16384);
    send(-128, 1'b1, 32768);
    send(-128, 1'b1, 49152);
    drain();

    // Backpressure with running sum of three
    do_flush();
    wr_coef(0, 1);
    wr_coef(1, 1);
    wr_coef(2, 1);
    fork
      begin
        for (int i = 1; i <= 10; i++) send(i, 1'b1, (i == 1) ? 1 : (i == 2) ? 3 : 3 * i - 3);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_data;
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (5) begin
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_hold", 32'(out_data), 32'(held));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Coefficient write lands with the accept of the fourth sample
    do_flush();
    send(2, 1'b1, 2);
    send(2, 1'b1, 4);
    send(2, 1'b1, 6);
    coef_we    = 1'b1;
    coef_addr  = 2'd1;
    coef_wdata = 8'd4;
    send(2, 1'b1, 12);
    coef_we = 1'b0;
    send(2, 1'b1, 12);
    send(2, 1'b1, 12);
    drain();

    // Flush with two samples in flight; c = {1,4,1}
    do_flush();
    send(10, 1'b0, 0);
    send(20, 1'b0, 0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_valid_1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_valid_2", 32'(out_valid), 32'd0);
    send(3, 1'b1, 3);
    send(0, 1'b1, 12);
    send(0, 1'b1, 3);
    drain();

    // Out-of-range coefficient address is ignored
    do_flush();
    wr_coef(3, 100);
    send(1, 1'b1, 1);
    send(0, 1'b1, 4);
    send(0, 1'b1, 1);
    drain();

    // Reset mid-stream with a stalled result
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_out_sat", 32'(out_sat), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(9, 1'b1, 0);
    send(9, 1'b1, 0);
    drain();

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_filter_n.md
Name: fir_filter_n

Overview:
Parametrised N-tap signed FIR filter; successor to the fixed 3-tap, 8-bit fir_filter. Coefficients are run-time programmable through a write port instead of static inputs. Adds streaming valid/ready handshakes with backpressure, a 2-stage pipeline and a synchronous flush. Sits between the sample source and downstream DSP stages.

Parameters:
TAPS, 3, number of taps (>=2)
DATA_W, 8, input sample width, signed two's complement
COEF_W, 8, coefficient width, signed two's complement
OUT_W, 16, output width; ACC_W = DATA_W+COEF_W+$clog2(TAPS); requires OUT_W <= ACC_W

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of delay line and pipeline valids; coefficients kept
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  tap index; 0 multiplies the newest sample
coef_wdata  in  COEF_W  coefficient value
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid && in_ready
in_data  in  DATA_W  signed sample
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  OUT_W  signed filter result
out_sat  out  1  result was clamped (FIR_SAT_EN only, else 0)

Behaviour:
- Reset (async, rst_n=0): delay line, coefficients, product regs, out_data, out_valid, out_sat, pipeline valid bits all 0. Outputs stay 0 until the first accepted sample drains.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational, no dependence on in_valid).
- Stage 0 (accept): on in_valid && in_ready, delay line shifts; x[0] <= in_data, x[k] <= x[k-1]. No shift without acceptance.
- Stage 1 (products): when adv, p[k] <= x'[k]*c[k] (full DATA_W+COEF_W signed), where x' is the post-shift line; v1 <= accepted.
- Stage 2 (sum): when adv, acc = sign-extended sum of p[k] at ACC_W (never overflows); out_data <= reduce(acc); out_valid <= v1.
- Latency: a sample accepted at edge N gives out_valid at edge N+2 under no backpressure. Throughput 1 sample/clk.
- Backpressure: out_valid && !out_ready freezes stages 1-2 and drops in_ready. out_data stays stable. No sample is lost or duplicated.
- Coefficient write: c[coef_addr] <= coef_wdata at the edge. A stage-1 capture on that same edge uses the old value. Writes are allowed while streaming. coef_addr >= TAPS is ignored.
- flush: delay line, v1, out_valid, out_sat cleared next edge. Priority over acceptance on the same cycle. A coef write on the same cycle still takes effect.
- reset mid-stream: all in-flight results discarded; coefficients return to 0.
- reduce(acc) default: out_data = acc[OUT_W-1:0] (wrap-around).

Optional Feature:
FIR_SAT_EN
- Defined: reduce(acc) clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat=1 on a clamped result, registered with out_data.
- Undefined: wrap truncation; out_sat tied 0; no clamp logic built.

Decomposition:
- Package fir_pkg: function acc_width(DATA_W,COEF_W,TAPS), sat/wrap reduce function, localparam for coef address width.
- One sub-module: fir_adder_tree (TAPS products in, ACC_W sum out, combinational), instantiated in stage 2.

Test Plan:
- Impulse: TAPS=3, c={5,-3,7}, in 1,0,0,0 back-to-back -> out 5,-3,7,0; first out_valid 2 clk after first accept.
- Worst case: c all -128, in -128 continuously -> acc 49152 (ACC_W=18); default wraps to out_data 0xC000. With FIR_SAT_EN: 32767 and out_sat=1.
- Backpressure: stream 1..10 with c={1,1,1}, out_ready low 5 clk mid-stream -> in_ready low, out_data held. Sequence 1,3,6,9,...,27 complete, no gaps or repeats.
- Coef update: stream constant 2, write c[1]=4 mid-stream -> outputs switch from old sum to new sum exactly at the documented edge.
- Flush/reset: flush with 2 results in flight -> out_valid 0 next clk, next outputs computed from zeroed history. rst_n low mid-stream -> all outputs 0 immediately, coefficients 0.
- Bad address: coef_we with coef_addr=3 (TAPS=3) -> no coefficient changes.
